reg_wb_ctrl: RTL and testbench
==============================

Name: reg_wb_ctrl

Overview:
Write-side controller for the 8x16 register file: the block that generates ld_reg/DR/global rather than consuming them. Execution units hand results in through a ready/valid port. Results are buffered in a small FIFO and retired one per cycle as register-file write strobes. It also keeps the NZP condition codes and a per-register pending-write scoreboard, which the decode stage queries on SR1/SR2 to stall on read-after-write hazards.

Parameters:
DEPTH, 2, writeback FIFO entries (power of two, 2..8)
CNTW, 2, width of per-register pending counter (max outstanding writes per register = 2^CNTW-1)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-high reset
wb_valid  in  1  result available
wb_ready  out  1  FIFO can accept
wb_dr  in  3  destination register of result
wb_data  in  16  result value
wb_setcc  in  1  result updates NZP
iss_valid  in  1  decode issues an instruction that will write iss_dr
iss_ready  out  1  scoreboard can record the issue
iss_dr  in  3  destination register being issued
SR1  in  3  source register 1 query
SR2  in  3  source register 2 query
sr1_busy  out  1  write pending to SR1 (combinational from counters)
sr2_busy  out  1  write pending to SR2
ld_reg  out  1  register-file write enable (registered)
DR  out  3  register-file write select (registered)
global  out  16  register-file write data (registered)
nzp  out  3  condition codes {N,Z,P}
sb_err  out  1  sticky: writeback to a register with zero pending count

Behaviour:
- Reset values: ld_reg=0, DR=0, global=0, nzp=3'b010, sb_err=0. FIFO is empty and all 8 pending counters are 0.
- Reset asserted mid-operation flushes queued results without writing them. All counters clear. An issue or push in the reset cycle is ignored.
- Push: wb_ready = (count < DEPTH), derived from registered count only, not from the same-cycle pop. A push occurs when wb_valid && wb_ready. A new entry is never written to a full FIFO.
- Pop: whenever the FIFO is non-empty at a clock edge, the head is popped. On that edge:
  - ld_reg <= 1, DR <= head.dr, global <= head.data.
  - If the FIFO is empty, ld_reg <= 0. DR and global hold their values.
- Latency: a result accepted at edge N into an empty FIFO appears with ld_reg=1 in the cycle after edge N+1. Throughput is 1 result per cycle sustained.
- Simultaneous push and pop: count is unchanged, and ordering stays FIFO. Pointers wrap modulo DEPTH.
- NZP update on a popped entry with setcc=1, evaluated on head.data:
  - data[15]=1 gives nzp=100.
  - data==0 gives nzp=010.
  - Otherwise nzp=001.
  - Exactly one bit is set at all times. NZP updates on the same edge that ld_reg rises. Entries with setcc=0 leave nzp unchanged.
- Scoreboard counters:
  - iss_ready = (cnt[iss_dr] != all-ones).
  - Issue (iss_valid && iss_ready) increments cnt[iss_dr].
  - Pop decrements cnt[head.dr].
  - Same register incremented and decremented on the same edge: counter unchanged.
  - Different registers: both updates apply.
- Underflow: a pop to a register whose counter is 0 leaves the counter at 0 and sets sb_err. The write itself still occurs. sb_err clears only on rst.
- Busy flags: sr1_busy = (cnt[SR1] != 0) and sr2_busy = (cnt[SR2] != 0). Both are combinational and reflect counters after the last edge. A register being written by the current ld_reg cycle already reads not-busy, because its counter decremented on the same edge. The register file's registered read therefore sees the new value one cycle later, and decode must account for that.
- No combinational path from wb_valid to wb_ready or from iss_valid to iss_ready.

Test Plan:
1. Reset, then push {dr=3, data=16'h8001, setcc=1}:
   - Next-edge cycle shows ld_reg=1, DR=3, global=16'h8001, nzp=100.
   - The following cycle shows ld_reg=0.
2. Scoreboard with SR1=5:
   - Issue dr=5 twice: cnt=2, sr1_busy=1.
   - Push two results to r5: sr1_busy stays 1 until the second ld_reg edge, then 0.
   - A third issue to r5 with cnt=3 gives iss_ready=0.
3. Back-to-back: with wb_valid held, push values 0, 7, 16'hFFFF (setcc=1).
   - ld_reg high 3 consecutive cycles in order.
   - nzp sequence is 010, 001, 100.
   - wb_ready never drops with DEPTH=2.
4. Full/backpressure: hold ld path busy by pushing 3 entries in consecutive cycles from empty while checking wb_ready.
   - Third push is accepted only when count<2.
   - No entry is lost or duplicated.
   - Order is preserved.
5. Same-edge issue and pop on r2: with cnt[2]=1, issue dr=2 while the r2 entry pops. cnt[2] remains 1 and sr2_busy=1 (SR2=2).
6. Underflow and reset:
   - Push to r6 with no prior issue: write occurs and sb_err=1.
   - Then queue 2 entries and assert rst for 1 cycle: no ld_reg afterwards, nzp=010, sb_err=0, all busy flags 0.

Source files
------------

// File: rtl/reg_wb_ctrl.sv
// Purpose: register-file write-side controller (writeback FIFO, NZP codes, RAW pending-write scoreboard).
// Latency: result pushed at edge N drives ld_reg/DR/global after edge N+1; one retire per cycle sustained.
// Backpressure: wb_ready from registered FIFO count only; iss_ready drops when the target counter saturates.
module reg_wb_ctrl #(
  parameter int DEPTH = 2,
  parameter int CNTW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  input  logic        wb_setcc,
  input  logic        iss_valid,
  output logic        iss_ready,
  input  logic [2:0]  iss_dr,
  input  logic [2:0]  SR1,
  input  logic [2:0]  SR2,
  output logic        sr1_busy,
  output logic        sr2_busy,
  output logic        ld_reg,
  output logic [2:0]  DR,
  output logic [15:0] global,
  output logic [2:0]  nzp,
  output logic        sb_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // Writeback FIFO storage; payload needs no reset because count gates every read.
  logic [2:0]      fifo_dr   [DEPTH];
  logic [15:0]     fifo_data [DEPTH];
  logic            fifo_cc   [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  // Per-register count of issued-but-not-yet-retired writes.
  logic [CNTW-1:0] cnt [8];

  logic            push, pop, issue;
  logic [2:0]      head_dr;
  logic [15:0]     head_data;
  logic            head_cc;
  logic [7:0]      inc_vec, dec_vec;
  logic            underflow;

  assign wb_ready  = (count < CW'(DEPTH));
  assign push      = wb_valid && wb_ready;
  assign pop       = (count != '0);
  assign iss_ready = (cnt[iss_dr] != '1);
  assign issue     = iss_valid && iss_ready;
  assign head_dr   = fifo_dr[rd_ptr];
  assign head_data = fifo_data[rd_ptr];
  assign head_cc   = fifo_cc[rd_ptr];
  assign sr1_busy  = (cnt[SR1] != '0);
  assign sr2_busy  = (cnt[SR2] != '0);

  // Decode issue/retire into per-register strobes; a retire matched by a same-edge
  // issue on the same register nets to zero and is not an underflow.
  always_comb begin
    inc_vec   = '0;
    dec_vec   = '0;
    for (int i = 0; i < 8; i++) begin
      inc_vec[i] = issue && (iss_dr == 3'(i));
      dec_vec[i] = pop && (head_dr == 3'(i));
    end
    underflow = pop && (cnt[head_dr] == '0) && !inc_vec[head_dr];
  end

  // FIFO payload write on accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dr[wr_ptr]   <= wb_dr;
      fifo_data[wr_ptr] <= wb_data;
      fifo_cc[wr_ptr]   <= wb_setcc;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Register-file write strobes and condition codes, updated as the head retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_reg <= 1'b0;
      DR     <= 3'd0;
      global <= 16'd0;
      nzp    <= 3'b010;
    end else begin
      ld_reg <= pop;
      if (pop) begin
        DR     <= head_dr;
        global <= head_data;
        if (head_cc) begin
          if (head_data[15])          nzp <= 3'b100;
          else if (head_data == '0)   nzp <= 3'b010;
          else                        nzp <= 3'b001;
        end
      end
    end
  end

  // Pending-write counters and sticky underflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + CNTW'(1);
        else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CNTW'(1);
      end
      if (underflow) sb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Directed bench for reg_wb_ctrl: writeback retire, NZP, scoreboard, flush on reset.
module tb_reg_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, wb_ready, wb_setcc;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_dr, SR1, SR2;
  logic        sr1_busy, sr2_busy, ld_reg, sb_err;
  logic [2:0]  DR, nzp;
  logic [15:0] rf_data;

  int cmps = 0;
  int errs = 0;

  reg_wb_ctrl #(.DEPTH(2), .CNTW(2)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dr(wb_dr),
    .wb_data(wb_data), .wb_setcc(wb_setcc),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_dr(iss_dr),
    .SR1(SR1), .SR2(SR2), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy),
    .ld_reg(ld_reg), .DR(DR), .global(rf_data), .nzp(nzp), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_set(input logic v, input logic [2:0] d, input logic [15:0] x, input logic cc);
    wb_valid = v; wb_dr = d; wb_data = x; wb_setcc = cc;
  endtask

  initial begin
    rst = 1'b1;
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    iss_valid = 1'b0; iss_dr = 3'd0; SR1 = 3'd0; SR2 = 3'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_ld_reg", 32'(ld_reg), 32'd0);
    chk("rst_DR", 32'(DR), 32'd0);
    chk("rst_global", 32'(rf_data), 32'd0);
    chk("rst_nzp", 32'(nzp), 32'b010);
    chk("rst_sb_err", 32'(sb_err), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);

    // 1: single result to r3 (issued on the same edge it is pushed)
    push_set(1'b1, 3'd3, 16'h8001, 1'b1);
    iss_valid = 1'b1; iss_dr = 3'd3;
    tick();
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    iss_valid = 1'b0;
    chk("t1_no_ld_yet", 32'(ld_reg), 32'd0);
    tick();
    chk("t1_ld_reg", 32'(ld_reg), 32'd1);
    chk("t1_DR", 32'(DR), 32'd3);
    chk("t1_global", 32'(rf_data), 32'h8001);
    chk("t1_nzp", 32'(nzp), 32'b100);
    tick();
    chk("t1_ld_drop", 32'(ld_reg), 32'd0);
    chk("t1_sb_err", 32'(sb_err), 32'd0);

    // 2: scoreboard on r5
    SR1 = 3'd5;
    iss_valid = 1'b1; iss_dr = 3'd5;
    tick(); tick();
    iss_valid = 1'b0;
    #1;
    chk("t2_busy_cnt2", 32'(sr1_busy), 32'd1);
    push_set(1'b1, 3'd5, 16'h0011, 1'b0);
    tick();
    push_set(1'b1, 3'd5, 16'h0022, 1'b0);
    chk("t2_busy_after_push", 32'(sr1_busy), 32'd1);
    tick();
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    chk("t2_ld1", 32'(ld_reg), 32'd1);
    chk("t2_data1", 32'(rf_data), 32'h0011);
    chk("t2_busy_mid", 32'(sr1_busy), 32'd1);
    tick();
    chk("t2_ld2", 32'(ld_reg), 32'd1);
    chk("t2_data2", 32'(rf_data), 32'h0022);
    chk("t2_busy_clear", 32'(sr1_busy), 32'd0);
    chk("t2_nzp_hold", 32'(nzp), 32'b100);
    iss_valid = 1'b1; iss_dr = 3'd5;
    tick(); tick();
    chk("t2_ready_cnt2", 32'(iss_ready), 32'd1);
    tick();
    chk("t2_ready_cnt3", 32'(iss_ready), 32'd0);
    iss_valid = 1'b0;

    // 3: back-to-back results to r1
    iss_valid = 1'b1; iss_dr = 3'd1;
    tick(); tick(); tick();
    iss_valid = 1'b0;
    push_set(1'b1, 3'd1, 16'h0000, 1'b1);
    #1 chk("t3_ready0", 32'(wb_ready), 32'd1);
    tick();
    push_set(1'b1, 3'd1, 16'h0007, 1'b1);
    #1 chk("t3_ready1", 32'(wb_ready), 32'd1);
    tick();
    chk("t3_ld_a", 32'(ld_reg), 32'd1);
    chk("t3_data_a", 32'(rf_data), 32'h0000);
    chk("t3_nzp_a", 32'(nzp), 32'b010);
    push_set(1'b1, 3'd1, 16'hFFFF, 1'b1);
    #1 chk("t3_ready2", 32'(wb_ready), 32'd1);
    tick();
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    chk("t3_ld_b", 32'(ld_reg), 32'd1);
    chk("t3_data_b", 32'(rf_data), 32'h0007);
    chk("t3_nzp_b", 32'(nzp), 32'b001);
    tick();
    chk("t3_ld_c", 32'(ld_reg), 32'd1);
    chk("t3_data_c", 32'(rf_data), 32'hFFFF);
    chk("t3_nzp_c", 32'(nzp), 32'b100);
    tick();
    chk("t3_ld_end", 32'(ld_reg), 32'd0);
    chk("t3_sb_err", 32'(sb_err), 32'd0);

    // 4: three consecutive pushes to r4 with matching issues; order, no loss or duplication
    iss_valid = 1'b1; iss_dr = 3'd4;
    push_set(1'b1, 3'd4, 16'h00A1, 1'b0);
    #1 chk("t4_ready0", 32'(wb_ready), 32'd1);
    tick();
    push_set(1'b1, 3'd4, 16'h00A2, 1'b0);
    chk("t4_ld_none", 32'(ld_reg), 32'd0);
    chk("t4_ready1", 32'(wb_ready), 32'd1);
    tick();
    chk("t4_data1", 32'(rf_data), 32'h00A1);
    chk("t4_dr1", 32'(DR), 32'd4);
    push_set(1'b1, 3'd4, 16'h00A3, 1'b0);
    chk("t4_ready2", 32'(wb_ready), 32'd1);
    tick();
    chk("t4_data2", 32'(rf_data), 32'h00A2);
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    iss_valid = 1'b0;
    tick();
    chk("t4_ld3", 32'(ld_reg), 32'd1);
    chk("t4_data3", 32'(rf_data), 32'h00A3);
    tick();
    chk("t4_no_dup", 32'(ld_reg), 32'd0);
    SR2 = 3'd4;
    #1 chk("t4_r4_idle", 32'(sr2_busy), 32'd0);
    chk("t4_sb_err", 32'(sb_err), 32'd0);

    // 5: issue to r2 on the edge its pending write retires
    SR2 = 3'd2;
    iss_valid = 1'b1; iss_dr = 3'd2;
    tick();
    iss_valid = 1'b0;
    push_set(1'b1, 3'd2, 16'h0005, 1'b0);
    tick();
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    iss_valid = 1'b1; iss_dr = 3'd2;
    tick();
    iss_valid = 1'b0;
    chk("t5_ld", 32'(ld_reg), 32'd1);
    chk("t5_DR", 32'(DR), 32'd2);
    chk("t5_busy", 32'(sr2_busy), 32'd1);
    iss_dr = 3'd2;
    #1 chk("t5_ready_cnt1", 32'(iss_ready), 32'd1);
    chk("t5_sb_err", 32'(sb_err), 32'd0);

    // 6: underflow on r6, then flush via reset
    push_set(1'b1, 3'd6, 16'h0000, 1'b1);
    tick();
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    tick();
    chk("t6_ld", 32'(ld_reg), 32'd1);
    chk("t6_DR", 32'(DR), 32'd6);
    chk("t6_nzp", 32'(nzp), 32'b010);
    chk("t6_sb_err", 32'(sb_err), 32'd1);
    push_set(1'b1, 3'd7, 16'hFFFF, 1'b1);
    tick();
    rst = 1'b1;
    push_set(1'b1, 3'd7, 16'h8000, 1'b1);
    iss_valid = 1'b1; iss_dr = 3'd0;
    tick();
    rst = 1'b0;
    push_set(1'b0, 3'd0, 16'd0, 1'b0);
    iss_valid = 1'b0;
    SR1 = 3'd5;
    SR2 = 3'd2;
    #1;
    chk("t6_rst_ld", 32'(ld_reg), 32'd0);
    chk("t6_rst_nzp", 32'(nzp), 32'b010);
    chk("t6_rst_sb_err", 32'(sb_err), 32'd0);
    chk("t6_rst_busy1", 32'(sr1_busy), 32'd0);
    chk("t6_rst_busy2", 32'(sr2_busy), 32'd0);
    tick();
    chk("t6_flush_ld_a", 32'(ld_reg), 32'd0);
    SR1 = 3'd0;
    #1 chk("t6_rst_issue_ignored", 32'(sr1_busy), 32'd0);
    tick();
    chk("t6_flush_ld_b", 32'(ld_reg), 32'd0);
    chk("t6_flush_nzp", 32'(nzp), 32'b010);
    chk("t6_global_rst", 32'(rf_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
